game_ctrl: RTL and testbench
============================

# game_ctrl

Frame-synchronous game-state controller for the dinosaur game, generalising the single-bit run/stop flag to a multi-hazard, multi-life, pausable state machine with score and speed generation. Sits beside the VGA, jump, ground and cactus blocks: it consumes the vertical sync, the player pixel and N hazard pixels, and drives `game_status`, `speed`, lives and score to the rest of the design. All state changes visible to the sprite blocks are committed only on a frame boundary.

## Interface
- `N_HAZARD`, 2: number of hazard pixel channels (cactus, bird, ...); 1..8.
- `LIVES`, 3: lives loaded at game start; 1..15.
- `INVUL_FRAMES`, 60: invulnerable frames after a non-fatal hit; 1..255.
- `SPEED_STEP`, 300: frames per speed increment; ≥1.
- `SPEED_MAX`, 9: speed saturation value; 1..15.
- `SCORE_W`, 16: score width.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `START`  in  1  start/restart button, active-high, already debounced.
- `PAUSE`  in  1  pause button, active-high, already debounced.
- `vs`  in  1  VGA vertical sync, generated in the `CLK` domain; low = blanking.
- `px_player`  in  1  player sprite pixel at the current scan position.
- `px_hazard`  in  N_HAZARD  hazard pixels, one per channel.
- `hazard_en`  in  N_HAZARD  per-channel collision enable mask.
- `game_status`  out  1  1 in RUN or HIT (world moving or frozen by pause).
- `paused`  out  1  pause in effect.
- `game_over`  out  1  1 in OVER.
- `hit`  out  1  1 in HIT (invulnerable; sprite blocks may blink).
- `lives`  out  4  remaining lives.
- `score`  out  SCORE_W  frames survived, unpaused.
- `speed`  out  4  world speed for ground/hazard blocks.

## Operation
- `frame_tick`: one-cycle pulse when registered `vs_q`=1 and `vs`=0 (falling edge). All state/output updates below occur on `frame_tick` unless stated.
- `START`/`PAUSE` rising edges detected per cycle into sticky `start_req` / `pause_req`; consumed (cleared) on the next `frame_tick`.
- `coll` = `px_player & |(px_hazard & hazard_en)`; latched per cycle into sticky `coll_pend` while in RUN and not paused; cleared on every `frame_tick`. A collision in the same cycle as `frame_tick` counts for that tick.
- States:
  - IDLE: `start_req` → RUN; load `lives`=LIVES, `score`=0, `speed`=1, step counter 0, `paused`=0.
  - RUN: `coll_pend|coll`: if `lives`==1 → OVER, `lives`=0; else `lives`−1, invul counter=INVUL_FRAMES, → HIT. Score/speed advance if not paused.
  - HIT: collisions ignored; if not paused, invul counter −1; at counter reaching 0 → RUN. Score/speed advance if not paused.
  - OVER: `speed`=0, score held; `start_req` → RUN with full reload as from IDLE.
- `pause_req` in RUN/HIT toggles `paused`; ignored in IDLE/OVER. `paused` forced 0 on leaving RUN/HIT.
- Score: +1 per unpaused tick in RUN/HIT, saturates at 2^SCORE_W−1.
- Speed: step counter counts unpaused ticks; at SPEED_STEP−1 wraps to 0 and `speed`+1, saturating at SPEED_MAX.
- `start_req` in RUN/HIT is discarded at the tick (no restart mid-game).

## Timing
- Reset (async, immediate): state IDLE; all outputs 0; `start_req`, `pause_req`, `coll_pend`, counters, `vs_q` = 0.
- Outputs are registered; they change in the cycle after `frame_tick`, never during active video.
- Button press → state change: at most one frame + 1 cycle.
- Collision → `lives` decrement: next `frame_tick` + 1 cycle.
- RESET asserted mid-frame or mid-HIT: all pending requests dropped; no tick processed until release.
- Priority at one tick in RUN: collision > pause toggle (pause still toggles; next frame evaluated paused).

## Test plan
- Reset, pulse START mid-frame → at next `vs` fall+1: `game_status`=1, `lives`=3, `speed`=1, `score`=0.
- RUN 300 frames, no collisions → `score`=300, `speed`=2; run to 2700 → `speed`=9 and stays 9 at 3000.
- Collision on hazard 1 with `hazard_en`=2'b10 → `lives`=2, `hit`=1 for exactly 60 frames; collision during HIT → `lives` unchanged; with `hazard_en`=2'b00 → no effect.
- Three spaced collisions → `game_over`=1, `lives`=0, `speed`=0, `score` frozen; START → RUN, `lives`=3, `score`=0.
- PAUSE during HIT for 20 frames → `score` and invul counter frozen, collisions ignored; PAUSE again → resume, HIT ends 20 frames later than unpaused.
- Collision pulse and `vs` fall in same cycle → counted; RESET asserted between two ticks in HIT → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and the rest of the dinosaur game:
// buttons, sync and pixels in, game state, lives, score and speed out.
interface game_ctrl_if #(
  parameter int N_HAZARD = 2,
  parameter int SCORE_W  = 16
);
  logic                start;
  logic                pause;
  logic                vs;
  logic                px_player;
  logic [N_HAZARD-1:0] px_hazard;
  logic [N_HAZARD-1:0] hazard_en;
  logic                game_status;
  logic                paused;
  logic                game_over;
  logic                hit;
  logic [3:0]          lives;
  logic [SCORE_W-1:0]  score;
  logic [3:0]          speed;

  // Environment side: drives buttons, sync and pixels, observes game state.
  modport master (
    output start, pause, vs, px_player, px_hazard, hazard_en,
    input  game_status, paused, game_over, hit, lives, score, speed
  );

  // Controller side.
  modport slave (
    input  start, pause, vs, px_player, px_hazard, hazard_en,
    output game_status, paused, game_over, hit, lives, score, speed
  );
endinterface

// File: rtl/game_ctrl.sv
// Frame-synchronous game-state controller: idle/run/hit/over with lives,
// invulnerability after a hit, pause, score and speed generation. Every
// visible state change is committed on the falling edge of vertical sync.
module game_ctrl #(
  parameter int N_HAZARD     = 2,
  parameter int LIVES        = 3,
  parameter int INVUL_FRAMES = 60,
  parameter int SPEED_STEP   = 300,
  parameter int SPEED_MAX    = 9,
  parameter int SCORE_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  game_ctrl_if.slave    bus
);

  localparam int STEP_W = $clog2(SPEED_STEP + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_OVER} state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d;
  logic                start_btn_q, start_btn_d;
  logic                pause_btn_q, pause_btn_d;
  logic                start_req_q, start_req_d;
  logic                pause_req_q, pause_req_d;
  logic                coll_pend_q, coll_pend_d;
  logic [7:0]          invul_q, invul_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [3:0]          lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          speed_q, speed_d;
  logic                paused_q, paused_d;
  logic                game_status_q, game_status_d;
  logic                game_over_q, game_over_d;
  logic                hit_q, hit_d;

  logic                frame_tick;
  logic                start_now;
  logic                pause_now;
  logic                coll_live;
  logic                coll_now;
  logic [N_HAZARD-1:0] hazard_masked;

  assign frame_tick    = vs_q & ~bus.vs;
  assign hazard_masked = bus.px_hazard & bus.hazard_en;
  // A collision only matters while the world is moving and vulnerable.
  assign coll_live     = bus.px_player & (|hazard_masked) & (state_q == S_RUN) & ~paused_q;
  assign coll_now      = coll_pend_q | coll_live;
  assign start_now     = start_req_q | (bus.start & ~start_btn_q);
  assign pause_now     = pause_req_q | (bus.pause & ~pause_btn_q);

  // Next-state logic: request/collision capture every cycle, game rules on frame ticks.
  always_comb begin
    state_d       = state_q;
    vs_d          = bus.vs;
    start_btn_d   = bus.start;
    pause_btn_d   = bus.pause;
    start_req_d   = start_now;
    pause_req_d   = pause_now;
    coll_pend_d   = coll_now;
    invul_d       = invul_q;
    step_d        = step_q;
    lives_d       = lives_q;
    score_d       = score_q;
    speed_d       = speed_q;
    paused_d      = paused_q;

    if (frame_tick) begin
      start_req_d = 1'b0;
      pause_req_d = 1'b0;
      coll_pend_d = 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_now) begin
            state_d  = S_RUN;
            lives_d  = 4'(LIVES);
            score_d  = '0;
            speed_d  = 4'd1;
            step_d   = '0;
            invul_d  = '0;
            paused_d = 1'b0;
          end
        end
        default: begin
          if (!paused_q) begin
            if (score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + 1'b1;
            end
            if (step_q == STEP_W'(SPEED_STEP - 1)) begin
              step_d = '0;
              if (speed_q < 4'(SPEED_MAX)) begin
                speed_d = speed_q + 4'd1;
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end
          if (state_q == S_RUN && coll_now) begin
            if (lives_q == 4'd1) begin
              state_d = S_OVER;
              lives_d = 4'd0;
            end else begin
              state_d = S_HIT;
              lives_d = lives_q - 4'd1;
              invul_d = 8'(INVUL_FRAMES);
            end
          end else if (state_q == S_HIT && !paused_q) begin
            if (invul_q <= 8'd1) begin
              invul_d = '0;
              state_d = S_RUN;
            end else begin
              invul_d = invul_q - 8'd1;
            end
          end
          if (pause_now) begin
            paused_d = ~paused_q;
          end
          if (state_d == S_OVER) begin
            paused_d = 1'b0;
            speed_d  = 4'd0;
          end
        end
      endcase
    end

    game_status_d = (state_d == S_RUN) || (state_d == S_HIT);
    game_over_d   = (state_d == S_OVER);
    hit_d         = (state_d == S_HIT);
  end

  // State and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vs_q          <= 1'b0;
      start_btn_q   <= 1'b0;
      pause_btn_q   <= 1'b0;
      start_req_q   <= 1'b0;
      pause_req_q   <= 1'b0;
      coll_pend_q   <= 1'b0;
      invul_q       <= '0;
      step_q        <= '0;
      lives_q       <= '0;
      score_q       <= '0;
      speed_q       <= '0;
      paused_q      <= 1'b0;
      game_status_q <= 1'b0;
      game_over_q   <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      start_btn_q   <= start_btn_d;
      pause_btn_q   <= pause_btn_d;
      start_req_q   <= start_req_d;
      pause_req_q   <= pause_req_d;
      coll_pend_q   <= coll_pend_d;
      invul_q       <= invul_d;
      step_q        <= step_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      speed_q       <= speed_d;
      paused_q      <= paused_d;
      game_status_q <= game_status_d;
      game_over_q   <= game_over_d;
      hit_q         <= hit_d;
    end
  end

  assign bus.game_status = game_status_q;
  assign bus.paused      = paused_q;
  assign bus.game_over   = game_over_q;
  assign bus.hit         = hit_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.speed       = speed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: short synthetic frames, a frame-level reference
// model of the game rules, and one task per scenario.
module tb_game_ctrl;

  localparam int N_HAZARD     = 2;
  localparam int LIVES        = 3;
  localparam int INVUL_FRAMES = 60;
  localparam int SPEED_STEP   = 300;
  localparam int SPEED_MAX    = 9;
  localparam int SCORE_W      = 16;
  localparam int ACT          = 6;
  localparam int BLK          = 2;
  localparam int VW           = 12 + SCORE_W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;
  localparam int M_OVER = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_ctrl_if #(.N_HAZARD(N_HAZARD), .SCORE_W(SCORE_W)) bus ();

  game_ctrl #(
    .N_HAZARD(N_HAZARD), .LIVES(LIVES), .INVUL_FRAMES(INVUL_FRAMES),
    .SPEED_STEP(SPEED_STEP), .SPEED_MAX(SPEED_MAX), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_st, m_lives, m_score, m_ticks, m_invul;
  bit m_paused, m_start, m_pause, m_coll;

  logic [VW-1:0] obs_vec;
  assign obs_vec = {bus.game_status, bus.paused, bus.game_over, bus.hit,
                    bus.lives, bus.score, bus.speed};

  // Expected output vector from the model: speed follows from total unpaused play ticks.
  function automatic logic [VW-1:0] exp_vec();
    int spd;
    logic playing, over, in_hit;
    playing = (m_st == M_RUN) || (m_st == M_HIT);
    over    = (m_st == M_OVER);
    in_hit  = (m_st == M_HIT);
    spd     = 0;
    if (playing) begin
      spd = 1 + m_ticks / SPEED_STEP;
      if (spd > SPEED_MAX) spd = SPEED_MAX;
    end
    return {playing, m_paused, over, in_hit, 4'(m_lives), SCORE_W'(m_score), 4'(spd)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_lives = 0; m_score = 0; m_ticks = 0; m_invul = 0;
    m_paused = 0; m_start = 0; m_pause = 0; m_coll = 0;
  endtask

  task automatic model_coll(input bit pl, input logic [N_HAZARD-1:0] hz, input logic [N_HAZARD-1:0] en);
    if (m_st == M_RUN && !m_paused && pl && ((hz & en) != '0)) m_coll = 1;
  endtask

  // Game rules applied once per frame boundary.
  task automatic model_tick();
    bit adv;
    if (m_st == M_IDLE || m_st == M_OVER) begin
      if (m_start) begin
        m_st = M_RUN; m_lives = LIVES; m_score = 0; m_ticks = 0; m_paused = 0;
      end
    end else begin
      adv = !m_paused;
      if (m_st == M_RUN && m_coll) begin
        if (m_lives == 1) begin
          m_st = M_OVER; m_lives = 0;
        end else begin
          m_lives--; m_invul = INVUL_FRAMES; m_st = M_HIT;
        end
      end else if (m_st == M_HIT && adv) begin
        m_invul--;
        if (m_invul == 0) m_st = M_RUN;
      end
      if (adv) begin
        if (m_score < (1 << SCORE_W) - 1) m_score++;
        m_ticks++;
      end
      if (m_pause) m_paused = !m_paused;
      if (m_st == M_OVER) m_paused = 0;
    end
    m_start = 0; m_pause = 0; m_coll = 0;
  endtask

  // One frame: buttons in cycle 0, optional collision in cycle 1 and/or on the vs-fall cycle.
  task automatic run_frame(input bit s, input bit p, input bit cact, input bit ctick,
                           input logic [N_HAZARD-1:0] hz, input logic [N_HAZARD-1:0] en,
                           input bit pl);
    for (int c = 0; c < ACT + BLK; c++) begin
      @(negedge clk);
      bus.vs    = (c < ACT);
      bus.start = s && (c == 0);
      bus.pause = p && (c == 0);
      bus.hazard_en = en;
      if ((cact && c == 1) || (ctick && c == ACT)) begin
        bus.px_player = pl;
        bus.px_hazard = hz;
        model_coll(pl, hz, en);
      end else begin
        bus.px_player = 1'b0;
        bus.px_hazard = '0;
      end
      if (s && c == 0) m_start = 1;
      if (p && c == 0) m_pause = 1;
      if (c == ACT + 1) model_tick();
    end
  endtask

  task automatic quiet_frame();
    run_frame(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_reset();
    bus.start = 0; bus.pause = 0; bus.vs = 1; bus.px_player = 0;
    bus.px_hazard = '0; bus.hazard_en = '0;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h want %h", obs_vec, exp_vec());
    end
    repeat (3) @(negedge clk);
    rst = 0;
    quiet_frame();
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("[TB] FAIL idle_no_start: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_start();
    run_frame(1, 0, 0, 0, '0, '0, 0);
    checks++;
    if (obs_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd3, SCORE_W'(0), 4'd1}) begin
      failures++;
      $display("[TB] FAIL start_load: got %h want game_status=1 lives=3 score=0 speed=1", obs_vec);
    end
  endtask

  task automatic test_speed();
    for (int f = 1; f <= 3000; f++) begin
      quiet_frame();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL speed_run frame %0d: got %h want %h", f, obs_vec, exp_vec());
      end
      if (f == 300) begin
        checks++;
        if (bus.score !== SCORE_W'(300) || bus.speed !== 4'd2) begin
          failures++;
          $display("[TB] FAIL speed_300: got score=%0d speed=%0d want 300/2", bus.score, bus.speed);
        end
      end
      if (f == 2700 || f == 3000) begin
        checks++;
        if (bus.speed !== 4'd9) begin
          failures++;
          $display("[TB] FAIL speed_sat frame %0d: got %0d want 9", f, bus.speed);
        end
      end
    end
  endtask

  task automatic test_hit();
    int hit_frames = 0;
    run_frame(0, 0, 1, 0, 2'b01, 2'b10, 1);
    checks++;
    if (obs_vec !== exp_vec() || bus.lives !== 4'd3) begin
      failures++;
      $display("[TB] FAIL masked_hazard: got %h want %h", obs_vec, exp_vec());
    end
    run_frame(0, 0, 1, 0, 2'b10, 2'b10, 1);
    checks++;
    if (obs_vec !== exp_vec() || bus.lives !== 4'd2 || bus.hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hit_entry: got %h want %h", obs_vec, exp_vec());
    end
    if (bus.hit) hit_frames++;
    for (int f = 0; f < 70; f++) begin
      run_frame(0, 0, (f < 50) && (f % 7 == 3), 0, 2'b11, 2'b11, 1);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL hit_window frame %0d: got %h want %h", f, obs_vec, exp_vec());
      end
      if (bus.hit) hit_frames++;
    end
    checks++;
    if (hit_frames != INVUL_FRAMES) begin
      failures++;
      $display("[TB] FAIL hit_length: got %0d frames want %0d", hit_frames, INVUL_FRAMES);
    end
    for (int f = 0; f < 4; f++) begin
      run_frame(0, 0, 1, 1, 2'b11, 2'b00, 1);
      checks++;
      if (obs_vec !== exp_vec() || bus.lives !== 4'd2) begin
        failures++;
        $display("[TB] FAIL enable_off: got %h want %h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_game_over();
    int frozen;
    for (int k = 0; k < 2; k++) begin
      run_frame(0, 0, 1, 0, 2'b01, 2'b01, 1);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL over_hit %0d: got %h want %h", k, obs_vec, exp_vec());
      end
      if (k == 0) repeat (INVUL_FRAMES + 2) quiet_frame();
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.lives !== 4'd0 || bus.speed !== 4'd0 || bus.game_status !== 1'b0) begin
      failures++;
      $display("[TB] FAIL over_state: got %h want game_over=1 lives=0 speed=0", obs_vec);
    end
    frozen = int'(bus.score);
    for (int f = 0; f < 5; f++) begin
      run_frame(0, (f == 2), 1, 0, 2'b11, 2'b11, 1);
      checks++;
      if (obs_vec !== exp_vec() || int'(bus.score) != frozen) begin
        failures++;
        $display("[TB] FAIL over_frozen: got %h want %h", obs_vec, exp_vec());
      end
    end
    run_frame(1, 0, 0, 0, '0, '0, 0);
    checks++;
    if (obs_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd3, SCORE_W'(0), 4'd1}) begin
      failures++;
      $display("[TB] FAIL restart: got %h want game_status=1 lives=3 score=0 speed=1", obs_vec);
    end
  endtask

  task automatic test_pause_hit();
    int hit_frames = 0;
    // Entry frame, 11 decrementing ticks, 20 frozen ticks, 48 more frames before the hit ends.
    run_frame(0, 0, 1, 0, 2'b10, 2'b11, 1);
    if (bus.hit) hit_frames++;
    for (int f = 0; f < 130; f++) begin
      run_frame(0, (f == 10) || (f == 30), (f > 10 && f < 30), 0, 2'b11, 2'b11, 1);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL pause_hit frame %0d: got %h want %h", f, obs_vec, exp_vec());
      end
      if (bus.hit) hit_frames++;
    end
    checks++;
    if (hit_frames != INVUL_FRAMES + 20) begin
      failures++;
      $display("[TB] FAIL pause_hit_length: got %0d frames want %0d", hit_frames, INVUL_FRAMES + 20);
    end
  endtask

  task automatic test_coll_at_tick();
    run_frame(0, 0, 0, 1, 2'b01, 2'b11, 1);
    checks++;
    if (obs_vec !== exp_vec() || bus.lives !== 4'd1 || bus.hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_at_tick: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_hit();
    quiet_frame();
    @(negedge clk);
    bus.vs = 1; bus.start = 1; bus.pause = 1;
    @(negedge clk);
    bus.start = 0; bus.pause = 0;
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("[TB] FAIL reset_mid_hit: got %h want %h", obs_vec, exp_vec());
    end
    repeat (2) @(negedge clk);
    rst = 0;
    quiet_frame();
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("[TB] FAIL reset_drops_req: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit s, p, ca, ct, pl;
    logic [N_HAZARD-1:0] hz, en;
    run_frame(1, 0, 0, 0, '0, '0, 0);
    for (int f = 0; f < 500; f++) begin
      s  = ($urandom_range(0, 24) == 0);
      p  = ($urandom_range(0, 11) == 0);
      ca = ($urandom_range(0, 3) == 0);
      ct = ($urandom_range(0, 7) == 0);
      pl = ($urandom_range(0, 3) != 0);
      hz = N_HAZARD'($urandom);
      en = N_HAZARD'($urandom);
      run_frame(s, p, ca, ct, hz, en, pl);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL random frame %0d: got %h want %h", f, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_speed();
    test_hit();
    test_game_over();
    test_pause_hit();
    test_coll_at_tick();
    test_reset_mid_hit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
